instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Fetch stage of the five-stage MIPS pipeline. It is the producer feeding the fetch/decode pipeline register. It owns the program counter and issues word reads to instruction memory over a wait-request handshake. It buffers one fetched instruction and presents it with PC+4, inserting NOP bubbles when memory is slow. It honours hazard-unit stalls and decode-stage branch redirects with one architectural delay slot.

## Interface
- RESET_VECTOR, 32'hBFC00000: first fetch address after reset.
- HALT_ADDRESS, 32'h00000000: fetching this address stops the unit.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- stall_fetch  in  1  hazard-unit stall; same signal as the fetch/decode register's active-low-sense enable (1 = hold).
- branch_taken_decode  in  1  decode stage redirects; qualified by !stall_fetch.
- branch_target_decode  in  32  redirect address; bits [1:0] ignored, treated as 00.
- imem_address  out  32  word address of the current read.
- imem_read  out  1  read request.
- imem_waitrequest  in  1  memory not ready; imem_address and imem_read must stay stable while high.
- imem_readdata  in  32  valid in the cycle imem_read=1 and imem_waitrequest=0 ("accept").
- instruction_fetch  out  32  buffered instruction, or 32'h0 (NOP) when the buffer is empty.
- program_counter_plus_four_fetch  out  32  address of the buffered instruction + 4, or 0 when the buffer is empty.
- active  out  1  0 once halted and drained.

## Operation
- Registers:
  - pc: next address to fetch.
  - buf_instr, buf_pcp4, buf_valid.
  - pend: redirect pending, plus pend_target.
  - squash.
  - state: FETCH, HOLD, HALTED.
- Consume: any cycle with stall_fetch=0 consumes the buffer. buf_valid<=0 unless an accept occurs in the same cycle.
- FETCH:
  - imem_read=1 and imem_address=pc.
  - On accept without squash: buf_instr<=readdata, buf_pcp4<=pc+4, buf_valid<=1, and pc<=pend ? pend_target : pc+4. pend clears.
  - On accept with squash: data is dropped, buf_valid unchanged, pc<=pend_target, squash and pend clear.
- HOLD (entered when buf_valid=1, stall_fetch=1 and no request in flight): imem_read=0. Return to FETCH when stall_fetch=0.
- Request rule: once imem_read rises, it stays high with the address unchanged until accept. This holds even if stall or redirect arrives mid-request. A new request starts only if the buffer is empty or consumed in that cycle.
- Invariant: an in-flight waiting request implies the buffer is empty at its accept, so a held buffer is never overwritten.
- Redirect (branch_taken_decode & !stall_fetch). The delay slot is the next instruction delivered after the branch.
  - buf_valid=1 (delay slot is in the buffer, consumed now): pc<=target. If an accept occurs this cycle, its data is dropped and buf_valid<=0. If a request is waiting (waitrequest=1), set squash and pend with target.
  - buf_valid=0 (delay slot not yet fetched): set pend with target. The next accepted fetch is the delay slot, and pc then takes the target.
- Halt: when pc==HALT_ADDRESS and no request is in flight, enter HALTED. imem_read=0. active falls once buf_valid=0. HALTED exits only via reset.

## Timing
- Reset (async, immediate):
  - pc=RESET_VECTOR; buf_valid=0, pend=0, squash=0, state=FETCH.
  - imem_read=0; instruction_fetch=0, program_counter_plus_four_fetch=0; active=1.
- First imem_read=1 occurs in the first clock after reset_n deasserts.
- Zero-wait memory: one instruction per cycle. An instruction accepted at edge N appears on outputs after edge N and is captured by the fetch/decode register at edge N+1.
- Each wait cycle produces one NOP bubble on the outputs.
- Reset asserted mid-request: request abandoned, buffer cleared, no further handshake obligation.

## Test plan
- Reset release, zero-wait memory returning addr-derived words: reads at BFC00000, BFC00004, BFC00008 on consecutive cycles; outputs pcp4 BFC00004, BFC00008 one cycle later.
- waitrequest high 3 cycles on BFC00004: address held 4 cycles; 3 NOP/pcp4=0 cycles on output; then BFC00004's word with pcp4 BFC00008.
- stall_fetch high 2 cycles with buffer full: imem_read=0, outputs frozen. Fetching resumes at the next address, with no duplicate and no loss.
- Branch at BFC00010 to 80000000, zero-wait: delay slot BFC00014 delivered, the BFC00018 accept is dropped, the next fetch is at 80000000.
- Same branch while the delay-slot read waits 2 cycles: BFC00014 delivered, next address 80000000, and BFC00018 is never requested.
- Redirect to 00000000: delay slot delivered, imem_read stays 0, and active falls after the delay slot is consumed.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the five-stage MIPS pipeline: owns the PC, reads instruction memory over a
// wait-request handshake and holds one instruction for the fetch/decode register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_fetch,
    input  logic        branch_taken_decode,
    input  logic [31:0] branch_target_decode,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic        imem_waitrequest,
    input  logic [31:0] imem_readdata,
    output logic [31:0] instruction_fetch,
    output logic [31:0] program_counter_plus_four_fetch,
    output logic        active
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_HALTED
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcp4;
    } fetch_buf_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    fetch_buf_t  buf_q, buf_d;
    logic        buf_valid_q, buf_valid_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        squash_q, squash_d;
    logic        wait_q, wait_d;

    logic        read_raw;
    logic        accept;
    logic        accept_data;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;

    assign imem_read       = read_raw & reset_n;
    assign imem_address    = pc_q;
    assign accept          = imem_read & ~imem_waitrequest;
    assign accept_data     = accept & ~squash_q;
    assign redirect        = branch_taken_decode & ~stall_fetch;
    assign redirect_target = branch_target_decode & ~32'h3;
    assign pc_plus4        = pc_q + 32'd4;

    assign instruction_fetch               = buf_valid_q ? buf_q.instr : 32'h0;
    assign program_counter_plus_four_fetch = buf_valid_q ? buf_q.pcp4  : 32'h0;
    assign active                          = ~((state_q == S_HALTED) & ~buf_valid_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_VECTOR;
            buf_q         <= '0;
            buf_valid_q   <= 1'b0;
            pend_q        <= 1'b0;
            pend_target_q <= 32'h0;
            squash_q      <= 1'b0;
            wait_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_q         <= buf_d;
            buf_valid_q   <= buf_valid_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
            squash_q      <= squash_d;
            wait_q        <= wait_d;
        end
    end

    // A request already waiting keeps imem_read high regardless of stall or halt.
    always_comb begin
        state_d  = state_q;
        read_raw = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!wait_q && pc_q == HALT_ADDRESS) begin
                    state_d = S_HALTED;
                end else if (!wait_q && buf_valid_q && stall_fetch) begin
                    state_d = S_HOLD;
                end else begin
                    read_raw = 1'b1;
                end
            end
            S_HOLD: begin
                if (!stall_fetch) state_d = S_FETCH;
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        buf_d         = buf_q;
        buf_valid_d   = buf_valid_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;
        squash_d      = squash_q;
        wait_d        = imem_read & imem_waitrequest;

        if (!stall_fetch) buf_valid_d = 1'b0;

        if (accept) begin
            if (squash_q) begin
                pc_d     = pend_target_q;
                squash_d = 1'b0;
                pend_d   = 1'b0;
            end else begin
                buf_d.instr = imem_readdata;
                buf_d.pcp4  = pc_plus4;
                buf_valid_d = 1'b1;
                pc_d        = pend_q ? pend_target_q : pc_plus4;
                pend_d      = 1'b0;
            end
        end

        if (redirect) begin
            if (buf_valid_q) begin
                // Delay slot leaves the buffer now; anything fetched after it is wrong-path.
                if (accept_data) begin
                    buf_valid_d = 1'b0;
                    pc_d        = redirect_target;
                end else if (imem_read && imem_waitrequest) begin
                    squash_d      = 1'b1;
                    pend_d        = 1'b1;
                    pend_target_d = redirect_target;
                end else begin
                    pc_d = redirect_target;
                end
            end else begin
                // Delay slot not yet buffered: it is either arriving now or the next accept.
                if (accept_data) begin
                    pc_d = redirect_target;
                end else begin
                    pend_d        = 1'b1;
                    pend_target_d = redirect_target;
                end
            end
        end
    end

endmodule
